// File: rtl/i_mem_loader.sv
// Instruction-memory loader: receives a length-prefixed byte stream and writes 16-bit words.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module i_mem_loader #(
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [15:0]           din,
    output logic                  w_en,
    output logic                  cpu_rst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    // state  | meaning
    // IDLE   | waiting for start after reset
    // LEN_HI | expecting high byte of word count
    // LEN_LO | expecting low byte of word count
    // DAT_HI | expecting high byte of next word
    // DAT_LO | expecting low byte; write issued next cycle
    // CHK    | expecting checksum byte (checksum build only)
    // DONE   | last load succeeded
    // ERROR  | last load failed its checksum
`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4, S_CHK = 3'd5, S_DONE = 3'd6, S_ERROR = 3'd7
    } state_t;
    localparam state_t S_AFTER_DATA = S_CHK;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_LEN_HI = 3'd1, S_LEN_LO = 3'd2, S_DAT_HI = 3'd3,
        S_DAT_LO = 3'd4, S_DONE = 3'd6, S_ERROR = 3'd7
    } state_t;
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t                state, state_nxt;
    logic                  accept;
    logic                  start_acc;
    logic [7:0]            len_hi;
    logic [15:0]           words_left;
    logic [7:0]            data_hi;
    logic [ADDR_WIDTH-1:0] wr_ptr;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            chk_sum;
`endif

    assign accept    = rx_valid & rx_ready;
    assign start_acc = start & ~busy;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE, S_ERROR: if (start) state_nxt = S_LEN_HI;
            S_LEN_HI: if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO: if (accept) state_nxt = ({len_hi, rx_data} == 16'd0) ? S_AFTER_DATA : S_DAT_HI;
            S_DAT_HI: if (accept) state_nxt = S_DAT_LO;
            // words_left is a down-counter; terminal count 1 means this is the last word
            S_DAT_LO: if (accept) state_nxt = (words_left == 16'd1) ? S_AFTER_DATA : S_DAT_HI;
`ifdef LOADER_CHECKSUM_EN
            S_CHK:    if (accept) state_nxt = (rx_data == chk_sum) ? S_DONE : S_ERROR;
`endif
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rx_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_DAT_HI, S_DAT_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
            end
            S_ERROR: error = 1'b1;
`endif
            S_DONE:  done = 1'b1;
            default: ;
        endcase
        cpu_rst = busy | (state == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_hi     <= '0;
            words_left <= '0;
            data_hi    <= '0;
            wr_ptr     <= BASE_ADDR;
            w_addr     <= BASE_ADDR;
            din        <= '0;
            w_en       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_sum    <= '0;
`endif
        end else begin
            w_en <= 1'b0;
            if (start_acc) begin
                wr_ptr <= BASE_ADDR;
`ifdef LOADER_CHECKSUM_EN
                chk_sum <= '0;
`endif
            end
            if (accept) begin
                case (state)
                    S_LEN_HI: len_hi <= rx_data;
                    S_LEN_LO: words_left <= {len_hi, rx_data};
                    S_DAT_HI: begin
                        data_hi <= rx_data;
`ifdef LOADER_CHECKSUM_EN
                        chk_sum <= chk_sum + rx_data;
`endif
                    end
                    S_DAT_LO: begin
                        w_en       <= 1'b1;
                        din        <= {data_hi, rx_data};
                        w_addr     <= wr_ptr;
                        wr_ptr     <= wr_ptr + 1'b1;
                        words_left <= words_left - 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        chk_sum    <= chk_sum + rx_data;
`endif
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i_mem_loader.sv
// Randomized bench for i_mem_loader: two instances (base 0 and base FFFF) share one stimulus stream.
module tb_i_mem_loader;
    localparam logic [15:0] BASE0 = 16'h0000;
    localparam logic [15:0] BASE1 = 16'hFFFF;

    logic        clk = 1'b0;
    logic        rst, start, rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready0, w_en0, cpu_rst0, busy0, done0, error0;
    logic        rx_ready1, w_en1, cpu_rst1, busy1, done1, error1;
    logic [15:0] w_addr0, din0, w_addr1, din1;

    i_mem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(BASE0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready0), .w_addr(w_addr0), .din(din0), .w_en(w_en0),
        .cpu_rst(cpu_rst0), .busy(busy0), .done(done0), .error(error0));

    i_mem_loader #(.ADDR_WIDTH(16), .BASE_ADDR(BASE1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready1), .w_addr(w_addr1), .din(din1), .w_en(w_en1),
        .cpu_rst(cpu_rst1), .busy(busy1), .done(done1), .error(error1));

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_wr0   = 0;
    int          n_wr1   = 0;
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [15:0] img[$];
    logic [7:0]  stream[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Every write strobe must match the next expected {addr,data} of its instance.
    always @(negedge clk) begin
        if (w_en0) begin
            if (exp_q0.size() == 0) check("unexpected_wr0", exp_q0.size(), 1);
            else check("wr0", {w_addr0, din0}, exp_q0.pop_front());
            n_wr0++;
        end
        if (w_en1) begin
            if (exp_q1.size() == 0) check("unexpected_wr1", exp_q1.size(), 1);
            else check("wr1", {w_addr1, din1}, exp_q1.pop_front());
            n_wr1++;
        end
    end

    task automatic push_expected(input int upto);
        for (int k = 0; k < upto; k++) begin
            exp_q0.push_back({16'(BASE0 + 16'(k)), img[k]});
            exp_q1.push_back({16'(BASE1 + 16'(k)), img[k]});
        end
    endtask

    task automatic build_stream(input bit bad_chk);
        logic [15:0] nn;
        logic [7:0]  sum;
        nn  = 16'(img.size());
        sum = 8'h00;
        stream.delete();
        stream.push_back(nn[15:8]);
        stream.push_back(nn[7:0]);
        foreach (img[k]) begin
            stream.push_back(img[k][15:8]);
            stream.push_back(img[k][7:0]);
            sum = sum + img[k][15:8] + img[k][7:0];
        end
`ifdef LOADER_CHECKSUM_EN
        stream.push_back(bad_chk ? 8'(sum + 8'd1) : sum);
`endif
    endtask

    task automatic check_reset();
        check("rst_rx_ready", rx_ready0, 0);
        check("rst_w_en", w_en0, 0);
        check("rst_w_addr0", w_addr0, BASE0);
        check("rst_w_addr1", w_addr1, BASE1);
        check("rst_din", din0, 0);
        check("rst_cpu_rst", cpu_rst0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_error", error0, 0);
    endtask

    // A garbage rx_valid pulse coincides with start; it must not be consumed.
    task automatic do_start();
        @(negedge clk);
        start    = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        @(negedge clk);
        start    = 1'b0;
        rx_valid = 1'b0;
        check("start_busy", busy0, 1);
        check("start_done_clr", done0, 0);
        check("start_error_clr", error0, 0);
        check("start_cpu_rst", cpu_rst0, 1);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
                start    = ($urandom_range(0, 3) == 0);
            end else begin
                start    = 1'b0;
                rx_valid = 1'b1;
                rx_data  = b;
                ok       = rx_ready0;
            end
        end
        if (!ok) check("rx_timeout", {31'b0, ok}, 1);
    endtask

    task automatic full_load(input bit gaps, input bit bad);
        n_wr0 = 0;
        n_wr1 = 0;
        push_expected(img.size());
        build_stream(bad);
        do_start();
        foreach (stream[i]) send_byte(stream[i], gaps);
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        for (int i = 0; i < 10 && busy0; i++) @(negedge clk);
        #1;
        check("end_busy", busy0, 0);
        check("end_done", done0, !bad);
        check("end_error", error0, bad);
        check("end_cpu_rst", cpu_rst0, bad);
        check("end_done1", done1, !bad);
        check("n_wr0", n_wr0, img.size());
        check("n_wr1", n_wr1, img.size());
        check("exp_q0_left", exp_q0.size(), 0);
        check("exp_q1_left", exp_q1.size(), 0);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int k = 0; k < n; k++) img.push_back(16'($urandom));
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (2) @(negedge clk);
        check_reset();
        rst = 1'b0;

        img.delete();
        img.push_back(16'h1234);
        img.push_back(16'hABCD);
        full_load(1'b0, 1'b0);

        img.delete();
        full_load(1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            random_image($urandom_range(1, 8));
            full_load(1'b1, 1'b0);
        end

`ifdef LOADER_CHECKSUM_EN
        random_image(3);
        full_load(1'b1, 1'b1);
        random_image(2);
        full_load(1'b1, 1'b0);
`endif

        // Reset after 3 of 5 words: later bytes must not write.
        random_image(5);
        n_wr0 = 0;
        n_wr1 = 0;
        push_expected(3);
        build_stream(1'b0);
        do_start();
        for (int i = 0; i < 8; i++) send_byte(stream[i], 1'b1);
        @(negedge clk);
        rx_valid = 1'b0;
        start    = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check_reset();
        rst = 1'b0;
        for (int i = 8; i < stream.size(); i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = stream[i];
        end
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_mid_n_wr0", n_wr0, 3);
        check("rst_mid_n_wr1", n_wr1, 3);
        check("rst_mid_busy", busy0, 0);

        random_image(4);
        full_load(1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
